regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the CPU's 16x16 register bank.
- Width, depth, hardwired-zero register and write-to-read bypass are configurable.
- Adds a per-register pending (scoreboard) bit so the control unit can stall on in-flight results.
- Replaces the single-cycle array clear with a one-entry-per-cycle sweep FSM that reports busy; sits between decode (reads and reservations) and writeback (writes).

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, if 1 entry 0 always reads 0 and ignores writes and reservations.
- BYPASS, 1, if 1 a same-cycle write is forwarded to read data and pending outputs.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  sync pulse; starts a clear sweep.
- clear_busy  out  1  high while the sweep runs.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- raddr_a  in  ADDR_W  read port A address.
- rdata_a  out  DATA_W  read port A data (combinational).
- raddr_b  in  ADDR_W  read port B address.
- rdata_b  out  DATA_W  read port B data (combinational).
- rsv_en  in  1  reserve (mark pending) request.
- rsv_addr  in  ADDR_W  register to reserve.
- pend_a  out  1  pending bit of raddr_a.
- pend_b  out  1  pending bit of raddr_b.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - all entries 0 and all pending bits 0;
  - FSM in IDLE, sweep counter 0, clear_busy 0.
  - Deasserting reset in the middle of a sweep leaves the block in IDLE with the array fully cleared.
- FSM states IDLE and SWEEP:
  - IDLE -> SWEEP when clear=1. In that same edge, all pending bits clear and counter loads 0.
  - In SWEEP, entry[counter] <= 0 each cycle and counter increments.
  - SWEEP -> IDLE on the edge that clears entry DEPTH-1, so the sweep lasts exactly DEPTH cycles.
  - clear_busy is registered: 1 from the cycle after the clear pulse through the last sweep cycle.
  - clear while in SWEEP is ignored (no restart).
- During SWEEP:
  - we and rsv_en are dropped;
  - rdata_a/b read 0 and pend_a/b read 0, whatever the un-swept contents.
- Write (IDLE, we=1): entry[waddr] <= wdata on the rising edge. With ZERO_REG=1 and waddr=0, the write is dropped.
- Read (combinational):
  - rdata_x = entry[raddr_x].
  - If BYPASS=1, we=1, waddr==raddr_x and the write is not dropped: rdata_x = wdata.
  - With ZERO_REG=1 and raddr_x=0: rdata_x = 0.
- Scoreboard (IDLE only):
  - a write to addr clears pend[addr] next edge;
  - rsv_en sets pend[rsv_addr] next edge;
  - write and reserve to the same addr in one cycle: the reserve wins, bit ends at 1 and the data is still written;
  - reserving an already pending register keeps it at 1, no error.
- pend_x (combinational) = pend[raddr_x]:
  - with BYPASS=1, forced 0 if a non-dropped write to raddr_x occurs this cycle and no same-cycle reserve targets raddr_x;
  - always 0 for entry 0 when ZERO_REG=1.
- Both read ports may address the same entry; there is no port conflict.
- Width rules: addresses are used unsigned and fully decoded (no out-of-range case); data is stored unmodified.

Decomposition:
- Shared package regfile_pkg: default DATA_W/ADDR_W constants, the FSM state enum (ST_IDLE, ST_SWEEP) and a function computing the per-port forward/zero select. The CPU top reuses the constants.
- One sub-module is natural: regfile_read_port, instantiated twice. It takes an address, the array, the pending vector and the write-bypass signals, and returns rdata and pend.

Test Plan:
- Reset then read: reset_n=0 then 1; read A=3, B=15 -> rdata 0x0000, pend 0, clear_busy 0.
- Write/read and bypass: write r5=0xBEEF, next cycle read A=5 -> 0xBEEF. Same cycle write r6=0x1234 with raddr_b=6 -> rdata_b=0x1234 combinationally (BYPASS=1).
- Zero register: write r0=0xFFFF, reserve r0 -> rdata_a(0)=0x0000, pend_a=0.
- Scoreboard:
  - reserve r7 -> pend_a(7)=1 next cycle;
  - write r7=0x0042 -> pend_a=0 in the write cycle (bypass) and 0 after;
  - simultaneous write + reserve r9 -> pend=1 and value written.
- Clear sweep: fill r1..r15 with nonzero values, pulse clear.
  - clear_busy is high exactly 16 cycles;
  - a second clear mid-sweep is ignored;
  - we during the sweep is dropped;
  - every entry reads 0 afterwards.
- Reset mid-sweep: pulse clear, assert reset_n=0 at sweep cycle 5 -> clear_busy falls immediately; after release the FSM is IDLE and all entries are 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, sweep FSM states and the read-port select helper for the
// parametrised register bank. The CPU top reuses the default widths from here.
package regfile_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } state_e;

  typedef enum logic [1:0] {
    SEL_ARRAY,
    SEL_FWD,
    SEL_ZERO
  } rsel_e;

  // A blanked port (sweep running or hardwired zero entry) beats forwarding.
  function automatic rsel_e readSel(input logic blank, input logic fwdHit);
    if (blank) begin
      return SEL_ZERO;
    end
    if (fwdHit) begin
      return SEL_FWD;
    end
    return SEL_ARRAY;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array lookup, write forwarding, zero-register
// and sweep blanking for both the data and the pending bit.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DEPTH    = 2 ** ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]             raddr_i,
  input  logic [DEPTH-1:0][DATA_W-1:0]  mem_i,
  input  logic [DEPTH-1:0]              pend_i,
  input  logic                          sweeping_i,
  input  logic                          weEff_i,
  input  logic [ADDR_W-1:0]             waddr_i,
  input  logic [DATA_W-1:0]             wdata_i,
  input  logic                          rsvEff_i,
  input  logic [ADDR_W-1:0]             rsvAddr_i,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          pend_o
);

  logic  blank;
  logic  fwdHit;
  logic  rsvHit;
  rsel_e sel;

  // A same-cycle reserve keeps the stored pending bit visible even while the
  // data itself is forwarded, because the reserve wins over the write.
  always_comb begin
    blank   = sweeping_i || ((ZERO_REG != 0) && (raddr_i == '0));
    fwdHit  = (BYPASS != 0) && weEff_i && (waddr_i == raddr_i);
    rsvHit  = rsvEff_i && (rsvAddr_i == raddr_i);
    sel     = readSel(blank, fwdHit);
    rdata_o = mem_i[raddr_i];
    pend_o  = pend_i[raddr_i];
    case (sel)
      SEL_ZERO: begin
        rdata_o = '0;
        pend_o  = 1'b0;
      end
      SEL_FWD: begin
        rdata_o = wdata_i;
        pend_o  = rsvHit ? pend_i[raddr_i] : 1'b0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register bank with per-entry pending bits and a one-entry-per-cycle clear
// sweep; decode reads and reserves, writeback writes.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  output logic              clear_busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              pend_a,
  output logic              pend_b
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [DEPTH-1:0]             pend_q;
  state_e                       state_q, state_d;
  logic [ADDR_W-1:0]            sweepCnt_q, sweepCnt_d;
  logic                         busy_q, busy_d;

  logic sweeping;
  logic weEff;
  logic rsvEff;

  assign sweeping   = (state_q == ST_SWEEP);
  assign weEff      = we && !sweeping && !((ZERO_REG != 0) && (waddr == '0));
  assign rsvEff     = rsv_en && !sweeping && !((ZERO_REG != 0) && (rsv_addr == '0));
  assign clear_busy = busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      sweepCnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweepCnt_q <= sweepCnt_d;
      busy_q     <= busy_d;
    end
  end

  // The sweep leaves on the edge that clears the last entry, so busy spans
  // exactly DEPTH cycles; a clear arriving mid-sweep is ignored.
  always_comb begin
    state_d    = state_q;
    sweepCnt_d = sweepCnt_q;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d    = ST_SWEEP;
          sweepCnt_d = '0;
          busy_d     = 1'b1;
        end
      end
      ST_SWEEP: begin
        sweepCnt_d = sweepCnt_q + ADDR_W'(1);
        if (sweepCnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '0;
    end else if (sweeping) begin
      mem_q[sweepCnt_q] <= '0;
    end else if (weEff) begin
      mem_q[waddr] <= wdata;
    end
  end

  // The reserve is applied after the write so it wins on a shared address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
    end else if (!sweeping && clear) begin
      pend_q <= '0;
    end else begin
      if (weEff) begin
        pend_q[waddr] <= 1'b0;
      end
      if (rsvEff) begin
        pend_q[rsv_addr] <= 1'b1;
      end
    end
  end

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_port_a (
    .raddr_i   (raddr_a),
    .mem_i     (mem_q),
    .pend_i    (pend_q),
    .sweeping_i(sweeping),
    .weEff_i   (weEff),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .rsvEff_i  (rsvEff),
    .rsvAddr_i (rsv_addr),
    .rdata_o   (rdata_a),
    .pend_o    (pend_a)
  );

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_port_b (
    .raddr_i   (raddr_b),
    .mem_i     (mem_q),
    .pend_i    (pend_q),
    .sweeping_i(sweeping),
    .weEff_i   (weEff),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .rsvEff_i  (rsvEff),
    .rsvAddr_i (rsv_addr),
    .rdata_o   (rdata_b),
    .pend_o    (pend_b)
  );

endmodule
